// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential chunked multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Width of a counter that must hold values 0..n-1 (minimum one bit).
  function automatic int unsigned step_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational partial-product generator: selects one A and one B chunk,
// multiplies them and shifts the result into its place in the full product.
module mult_pp_gen
  import mult_pkg::*;
#(
  parameter  int unsigned A_W     = 32,
  parameter  int unsigned B_W     = 32,
  parameter  int unsigned A_CHUNK = 8,
  parameter  int unsigned B_CHUNK = 16,
  localparam int unsigned IA_W    = step_w(A_W / A_CHUNK),
  localparam int unsigned IB_W    = step_w(B_W / B_CHUNK),
  localparam int unsigned P_W     = A_W + B_W
) (
  input  logic [A_W-1:0]  a,
  input  logic [B_W-1:0]  b,
  input  logic [IA_W-1:0] ia,
  input  logic [IB_W-1:0] ib,
  output logic [P_W-1:0]  pp
);

  localparam int unsigned PP_W = A_CHUNK + B_CHUNK;

  logic [A_CHUNK-1:0] a_slice;
  logic [B_CHUNK-1:0] b_slice;
  logic [PP_W-1:0]    prod;

  always_comb begin
    a_slice = A_CHUNK'(a >> (32'(ia) * A_CHUNK));
    b_slice = B_CHUNK'(b >> (32'(ib) * B_CHUNK));
    prod    = PP_W'(a_slice) * PP_W'(b_slice);
    pp      = P_W'(prod) << (32'(ia) * A_CHUNK + 32'(ib) * B_CHUNK);
  end

endmodule

// File: rtl/mult_seq_param.sv
// Multi-cycle chunked multiplier with start/busy/done handshake.
// Define MULT_SIGNED_EN to add the signed_mode port and two's-complement support.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter  int unsigned A_W     = 32,
  parameter  int unsigned B_W     = 32,
  parameter  int unsigned A_CHUNK = 8,
  parameter  int unsigned B_CHUNK = 16,
  localparam int unsigned P_W     = A_W + B_W
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic           signed_mode,
`endif
  output logic           busy,
  output logic           done,
  output logic [P_W-1:0] product
);

  localparam int unsigned NA     = A_W / A_CHUNK;
  localparam int unsigned NB     = B_W / B_CHUNK;
  localparam int unsigned STEPS  = NA * NB;
  localparam int unsigned STEP_W = step_w(STEPS);
  localparam int unsigned IA_W   = step_w(NA);
  localparam int unsigned IB_W   = step_w(NB);

  if ((A_W % A_CHUNK) != 0 || (B_W % B_CHUNK) != 0) begin : g_chunk_check
    $fatal(1, "mult_seq_param: A_W/B_W must be multiples of A_CHUNK/B_CHUNK");
  end

  mult_state_t state, next_state;

  logic [A_W-1:0]    a_lat, a_in;
  logic [B_W-1:0]    b_lat, b_in;
  logic [STEP_W-1:0] cnt;
  logic [IA_W-1:0]   ia;
  logic [IB_W-1:0]   ib;
  logic [P_W-1:0]    pp, sum, result;
  logic              accept, last;

`ifdef MULT_SIGNED_EN
  logic neg, neg_in, sign_a, sign_b;

  // Magnitudes are latched; the most-negative value maps onto itself as unsigned.
  always_comb begin
    sign_a = signed_mode & a[A_W-1];
    sign_b = signed_mode & b[B_W-1];
    a_in   = sign_a ? -a : a;
    b_in   = sign_b ? -b : b;
    neg_in = sign_a ^ sign_b;
  end
`else
  always_comb begin
    a_in = a;
    b_in = b;
  end
`endif

  mult_pp_gen #(
    .A_W    (A_W),
    .B_W    (B_W),
    .A_CHUNK(A_CHUNK),
    .B_CHUNK(B_CHUNK)
  ) u_pp_gen (
    .a (a_lat),
    .b (b_lat),
    .ia(ia),
    .ib(ib),
    .pp(pp)
  );

  always_comb begin
    accept = start && (state != RUN);
    last   = (cnt == STEP_W'(STEPS - 1));
    sum    = product + pp;
`ifdef MULT_SIGNED_EN
    result = (last && neg) ? -sum : sum;
`else
    result = sum;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = start ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_lat   <= '0;
      b_lat   <= '0;
      cnt     <= '0;
      ia      <= '0;
      ib      <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else if (accept) begin
      a_lat   <= a_in;
      b_lat   <= b_in;
      cnt     <= '0;
      ia      <= '0;
      ib      <= '0;
      product <= '0;
`ifdef MULT_SIGNED_EN
      neg     <= neg_in;
`endif
    end else if (state == RUN) begin
      cnt     <= cnt + 1'b1;
      product <= result;
      // ia walks fastest; ib advances each time ia wraps.
      if (ia == IA_W'(NA - 1)) begin
        ia <= '0;
        ib <= ib + 1'b1;
      end else begin
        ia <= ia + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param: vector table, scoreboard and corner-case sequences.
module tb_mult_seq_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a_in, b_in;
  logic        signed_mode;
  logic        busy, done;
  logic [63:0] product;

  logic        start2;
  logic [15:0] a2, b2;
  logic        busy2, done2;
  logic [31:0] product2;

  int tests = 0;
  int fails = 0;
  logic [63:0] q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  mult_seq_param dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a_in),
    .b      (b_in),
`ifdef MULT_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  mult_seq_param #(
    .A_W    (16),
    .B_W    (16),
    .A_CHUNK(8),
    .B_CHUNK(8)
  ) dut2 (
    .clk    (clk),
    .reset  (reset),
    .start  (start2),
    .a      (a2),
    .b      (b2),
`ifdef MULT_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .busy   (busy2),
    .done   (done2),
    .product(product2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) check("unexpected done", 64'd1, 64'd0);
      else               check("product at done", product, q.pop_front());
    end
  end

  task automatic wait_done(input string name, output int bc);
    bit found = 0;
    bc = 0;
    for (int g = 0; g < 64; g++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
      if (busy) bc++;
    end
    if (!found) check({name, " done timeout"}, 64'd0, 64'd1);
  endtask

  // Called #1 after a rising edge with the DUT idle; returns likewise.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    int bc;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back(exp);
    a_in  = $urandom;
    b_in  = $urandom;
    wait_done(name, bc);
    check({name, " busy cycles"}, 64'(bc), 64'd8);
    @(negedge clk);
    check({name, " done width"}, 64'(done), 64'd0);
    check({name, " product hold"}, product, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int bc;
    int dcount;
    logic [31:0] ra, rb;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080};
    vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vecs[3] = '{32'h0000_0001, 32'h0000_0001, 64'h1};
    vecs[4] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[5] = '{32'hFF00_0000, 32'hFFFF_0000, 64'hFEFF_0100_0000_0000};
    for (int i = 6; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      vecs[i] = '{ra, rb, {32'b0, ra} * {32'b0, rb}};
    end

    reset       = 1'b1;
    start       = 1'b0;
    start2      = 1'b0;
    signed_mode = 1'b0;
    a_in = '0; b_in = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    check("reset product2", 64'(product2), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

    // Second start at RUN cycle 3 with zero operands must be ignored.
    a_in = 32'h1234_5678; b_in = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; q.push_back(64'h0B00_EA4E_242D_2080);
    a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ignored start", bc);
    @(negedge clk);
    check("ignored start busy after", 64'(busy), 64'd0);
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("ignored start no second done", 64'(dcount), 64'd0);
    @(posedge clk); #1;

    // Back-to-back: start held through DONE.
    a_in = 32'd2; b_in = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    q.push_back(64'd18);
    a_in = 32'd3; b_in = 32'd5;
    wait_done("b2b first", bc);
    check("b2b first busy cycles", 64'(bc), 64'd8);
    check("b2b busy in done", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back(64'd15);
    @(negedge clk);
    check("b2b no idle cycle", 64'(busy), 64'd1);
    wait_done("b2b second", bc);
    check("b2b second busy cycles", 64'(bc), 64'd7);
    @(posedge clk); #1;

    // Reset in RUN cycle 4: immediate clear, no done, then a clean run.
    a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid reset busy", 64'(busy), 64'd0);
    check("mid reset product", product, 64'd0);
    @(negedge clk) reset = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("mid reset no done", 64'(dcount), 64'd0);
    @(posedge clk); #1;
    do_op("after reset 7*6", 32'd7, 32'd6, 64'd42);

    // Narrow parameter set: 2x2 chunks.
    a2 = 16'hFFFF; b2 = 16'h0002; start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    bc = 0; dcount = 0;
    for (int g = 0; g < 32; g++) begin
      @(negedge clk);
      if (done2) begin
        dcount = 1;
        break;
      end
      if (busy2) bc++;
    end
    check("p16 done seen", 64'(dcount), 64'd1);
    check("p16 busy cycles", 64'(bc), 64'd4);
    check("p16 product", 64'(product2), 64'h0001_FFFE);
    @(negedge clk);
    check("p16 done width", 64'(done2), 64'd0);
    @(posedge clk); #1;

`ifdef MULT_SIGNED_EN
    signed_mode = 1'b1;
    do_op("s -1*2", 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("s min*min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_op("s -1*-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
    do_op("s 3*-5", 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
    signed_mode = 1'b0;
    do_op("u ffffffff*2", 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    do_op("u min*min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
`endif

    check("scoreboard drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
